// File: rtl/rgmii_rx_frame_ctrl.sv
// RGMII receive framer: strips preamble/SFD, streams frame bytes, flags bad frames.
// Optional FCS check enabled by defining RGMII_RX_FCS_CHECK_EN.
module rgmii_rx_frame_ctrl (
    input  logic        clk125MHz,
    input  logic        rst,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_dv_in,
    input  logic        rx_er_in,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        out_bad,
    output logic [15:0] frame_ok_cnt,
    output logic [15:0] frame_bad_cnt,
    output logic        busy
);

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DROP
    } state_t;

    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [10:0] MIN_LEN  = 11'd64;
    localparam logic [10:0] MAX_LEN  = 11'd1518;
    localparam logic [10:0] LEN_SAT  = 11'd2047;

    state_t      state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        held_q, held_d;
    logic [10:0] len_q, len_d;
    logic        err_q, err_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        bad_q, bad_d;
    logic [15:0] ok_cnt_q, ok_cnt_d;
    logic [15:0] bad_cnt_q, bad_cnt_d;
    logic        len_bad;
    logic        frame_bad;

    assign len_bad = (len_q < MIN_LEN) || (len_q > MAX_LEN);

`ifdef RGMII_RX_FCS_CHECK_EN
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE  = 32'hC704_DD7B;

    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_rev;

    // Reflected CRC-32, one byte per call, LSB first
    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (state_q == PREAMBLE && rx_dv_in && rx_data_in == SFD_BYTE) begin
            crc_d = CRC_INIT;
        end else if (state_q == PAYLOAD && rx_dv_in) begin
            crc_d = crc_byte(crc_q, rx_data_in);
        end
    end

    // The shift-right register holds the residue bit-reversed
    always_comb begin
        crc_rev = '0;
        for (int i = 0; i < 32; i++) begin
            crc_rev[i] = crc_q[31-i];
        end
    end

    assign frame_bad = len_bad | err_q | (crc_rev != RESIDUE);

    always_ff @(posedge clk125MHz or posedge rst) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end
`else
    assign frame_bad = len_bad | err_q;
`endif

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        hold_d    = hold_q;
        held_d    = held_q;
        len_d     = len_q;
        err_d     = err_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        bad_d     = 1'b0;
        ok_cnt_d  = ok_cnt_q;
        bad_cnt_d = bad_cnt_q;
        unique case (state_q)
            SYNC: begin
                if (!rx_dv_in) state_d = IDLE;
            end
            IDLE: begin
                if (rx_dv_in) begin
                    if (rx_data_in == PRE_BYTE) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = 3'd1;
                    end else begin
                        state_d   = DROP;
                        bad_cnt_d = bad_cnt_q + 16'd1;
                    end
                end
            end
            PREAMBLE: begin
                if (!rx_dv_in) begin
                    state_d   = IDLE;
                    bad_cnt_d = bad_cnt_q + 16'd1;
                end else if (rx_data_in == SFD_BYTE) begin
                    state_d = PAYLOAD;
                    held_d  = 1'b0;
                    len_d   = '0;
                    err_d   = rx_er_in;
                end else if (rx_data_in == PRE_BYTE && pre_cnt_q != 3'd7) begin
                    pre_cnt_d = pre_cnt_q + 3'd1;
                end else begin
                    state_d   = DROP;
                    bad_cnt_d = bad_cnt_q + 16'd1;
                end
            end
            PAYLOAD: begin
                if (rx_dv_in) begin
                    if (held_q) begin
                        data_d  = hold_q;
                        valid_d = 1'b1;
                    end
                    hold_d = rx_data_in;
                    held_d = 1'b1;
                    err_d  = err_q | rx_er_in;
                    if (len_q != LEN_SAT) len_d = len_q + 11'd1;
                end else begin
                    state_d = IDLE;
                    held_d  = 1'b0;
                    if (held_q) begin
                        data_d  = hold_q;
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        bad_d   = frame_bad;
                        if (frame_bad) bad_cnt_d = bad_cnt_q + 16'd1;
                        else           ok_cnt_d  = ok_cnt_q + 16'd1;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 16'd1;
                    end
                end
            end
            DROP: begin
                if (!rx_dv_in) state_d = IDLE;
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk125MHz or posedge rst) begin
        if (rst) begin
            state_q   <= SYNC;
            pre_cnt_q <= '0;
            hold_q    <= '0;
            held_q    <= 1'b0;
            len_q     <= '0;
            err_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            bad_q     <= 1'b0;
            ok_cnt_q  <= '0;
            bad_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            hold_q    <= hold_d;
            held_q    <= held_d;
            len_q     <= len_d;
            err_q     <= err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            bad_q     <= bad_d;
            ok_cnt_q  <= ok_cnt_d;
            bad_cnt_q <= bad_cnt_d;
        end
    end

    assign out_data      = data_q;
    assign out_valid     = valid_q;
    assign out_last      = last_q;
    assign out_bad       = bad_q;
    assign frame_ok_cnt  = ok_cnt_q;
    assign frame_bad_cnt = bad_cnt_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rgmii_rx_frame_ctrl.sv
// Bench for rgmii_rx_frame_ctrl: cycle stimulus list, frame-level reference
// model and a per-cycle compare process.
module tb_rgmii_rx_frame_ctrl;

    logic        clk125MHz;
    logic        rst;
    logic [7:0]  rx_data_in;
    logic        rx_dv_in;
    logic        rx_er_in;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_bad;
    logic [15:0] frame_ok_cnt;
    logic [15:0] frame_bad_cnt;
    logic        busy;

    rgmii_rx_frame_ctrl dut (
        .clk125MHz    (clk125MHz),
        .rst          (rst),
        .rx_data_in   (rx_data_in),
        .rx_dv_in     (rx_dv_in),
        .rx_er_in     (rx_er_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_bad      (out_bad),
        .frame_ok_cnt (frame_ok_cnt),
        .frame_bad_cnt(frame_bad_cnt),
        .busy         (busy)
    );

    initial clk125MHz = 1'b0;
    always #4 clk125MHz = ~clk125MHz;

    bit         s_rst[$];
    bit         s_dv[$];
    bit         s_er[$];
    logic [7:0] s_dat[$];
    logic [7:0] pl[$];

    bit         e_val[];
    bit         e_last[];
    bit         e_bad[];
    bit         e_busy[];
    logic [7:0] ev_dat[];
    logic [7:0] e_dat[];
    int         e_ok[];
    int         e_bc[];
    int         inc_ok[];
    int         inc_bad[];

    int  nc;
    int  cur;
    bit  active;
    int  n_chk;
    int  n_fail;
    int  sfd_at;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB8_8320;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input int cyc,
                       input logic [31:0] a, input logic [31:0] x);
        n_chk++;
        if (a !== x) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, a, x);
        end
    endtask

    task automatic push(input bit r, input bit v, input bit er, input logic [7:0] d);
        s_rst.push_back(r);
        s_dv.push_back(v);
        s_er.push_back(er);
        s_dat.push_back(d);
    endtask

    task automatic idle(input int n);
        repeat (n) push(1'b0, 1'b0, 1'b0, 8'($urandom));
    endtask

    // Payload of n bytes: n-4 random bytes followed by their FCS, LSB first
    task automatic mk_pl(input int n);
        logic [31:0] c;
        pl.delete();
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n - 4; i++) begin
            pl.push_back(8'($urandom));
            c = crc_step(c, pl[i]);
        end
        c = ~c;
        pl.push_back(c[7:0]);
        pl.push_back(c[15:8]);
        pl.push_back(c[23:16]);
        pl.push_back(c[31:24]);
    endtask

    task automatic send(input int pre, input int er_at);
        repeat (pre) push(1'b0, 1'b1, 1'b0, 8'h55);
        sfd_at = s_dv.size();
        push(1'b0, 1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < pl.size(); i++)
            push(1'b0, 1'b1, (i == er_at), pl[i]);
    endtask

    task automatic classify(input int r, input int e);
        int          l;
        int          p;
        int          s;
        int          n;
        bit          fin;
        bit          bad;
        logic [31:0] c;
        l   = e - r;
        fin = (e < nc) && !s_rst[e];
        p   = 0;
        while (p < l && p < 8 && s_dat[r+p] == 8'h55) p++;
        if (p == 0) begin
            inc_bad[r]++;
        end else if (p >= 8) begin
            inc_bad[r+7]++;
        end else if (p == l) begin
            if (fin) inc_bad[e]++;
        end else if (s_dat[r+p] != 8'hD5) begin
            inc_bad[r+p]++;
        end else begin
            s = r + p;
            n = l - p - 1;
            for (int k = 1; k < n; k++) begin
                e_val[s+k+1]  = 1'b1;
                ev_dat[s+k+1] = s_dat[s+k];
            end
            if (fin) begin
                if (n == 0) begin
                    inc_bad[e]++;
                end else begin
                    bad = (n < 64) || (n > 1518);
                    for (int k = s; k < e; k++) bad = bad | s_er[k];
`ifdef RGMII_RX_FCS_CHECK_EN
                    if (n >= 4) begin
                        c = 32'hFFFF_FFFF;
                        for (int k = s + 1; k < e - 4; k++) c = crc_step(c, s_dat[k]);
                        if (~c != {s_dat[e-1], s_dat[e-2], s_dat[e-3], s_dat[e-4]})
                            bad = 1'b1;
                    end
`endif
                    e_val[e]  = 1'b1;
                    e_last[e] = 1'b1;
                    e_bad[e]  = bad;
                    ev_dat[e] = s_dat[e-1];
                    if (bad) inc_bad[e]++;
                    else     inc_ok[e]++;
                end
            end
        end
    endtask

    task automatic build_model();
        int  c;
        int  r;
        int  e;
        bit  sync;
        int  okc;
        int  bdc;
        logic [7:0] hd;
        nc = s_dv.size();
        e_val = new[nc]; e_last = new[nc]; e_bad = new[nc]; e_busy = new[nc];
        ev_dat = new[nc]; e_dat = new[nc]; e_ok = new[nc]; e_bc = new[nc];
        inc_ok = new[nc]; inc_bad = new[nc];
        sync = 1'b1;
        c = 0;
        while (c < nc) begin
            if (s_rst[c]) begin
                sync = 1'b1;
                c++;
            end else if (!s_dv[c]) begin
                sync = 1'b0;
                c++;
            end else begin
                r = c;
                e = c;
                while (e < nc && s_dv[e] && !s_rst[e]) e++;
                if (!sync) classify(r, e);
                c = e;
            end
        end
        okc = 0; bdc = 0; hd = 8'h00;
        for (int i = 0; i < nc; i++) begin
            if (s_rst[i]) begin
                okc = 0; bdc = 0; hd = 8'h00;
                e_val[i] = 1'b0; e_last[i] = 1'b0; e_bad[i] = 1'b0;
            end else begin
                okc += inc_ok[i];
                bdc += inc_bad[i];
                if (e_val[i]) hd = ev_dat[i];
            end
            e_ok[i]   = okc;
            e_bc[i]   = bdc;
            e_dat[i]  = hd;
            e_busy[i] = s_rst[i] | s_dv[i];
        end
    endtask

    function automatic int beats(input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i < b; i++) if (e_val[i]) n++;
        return n;
    endfunction

    always @(negedge clk125MHz) begin
        if (active) begin
            chk("out_valid", cur, 32'(out_valid), 32'(e_val[cur]));
            chk("out_last", cur, 32'(out_last), 32'(e_last[cur]));
            if (e_last[cur]) chk("out_bad", cur, 32'(out_bad), 32'(e_bad[cur]));
            chk("out_data", cur, 32'(out_data), 32'(e_dat[cur]));
            chk("frame_ok_cnt", cur, 32'(frame_ok_cnt), 32'(e_ok[cur] & 16'hFFFF));
            chk("frame_bad_cnt", cur, 32'(frame_bad_cnt), 32'(e_bc[cur] & 16'hFFFF));
            chk("busy", cur, 32'(busy), 32'(e_busy[cur]));
        end
    end

    initial begin
        int m1, m2, m3, m4, m5, m6, m7, m8;
        int sfd1, sfd2;
        logic [31:0] c;
        n_chk = 0; n_fail = 0; active = 1'b0; cur = 0;
        rst = 1'b1; rx_dv_in = 1'b0; rx_er_in = 1'b0; rx_data_in = 8'h00;

        repeat (3) push(1'b1, 1'b0, 1'b0, 8'h00);
        idle(3);
        mk_pl(64); send(7, -1); sfd1 = sfd_at; idle(4); m1 = s_dv.size() - 1;
        mk_pl(63); send(7, -1); sfd2 = sfd_at; idle(4); m2 = s_dv.size() - 1;
        mk_pl(100); pl[20] = pl[20] ^ 8'h01; send(7, -1); idle(4); m3 = s_dv.size() - 1;
        push(0, 1, 0, 8'h55); push(0, 1, 0, 8'h55); push(0, 1, 0, 8'h12);
        for (int i = 0; i < 10; i++) push(0, 1, 0, 8'($urandom));
        idle(2);
        mk_pl(64); send(8, -1); idle(2);
        mk_pl(64); send(7, 10); idle(2);
        repeat (3) push(0, 1, 0, 8'h55); idle(2);
        repeat (5) push(0, 1, 0, 8'h55); push(0, 1, 0, 8'hD5); idle(2);
        push(0, 1, 0, 8'hA7); push(0, 1, 0, 8'h55); idle(3); m4 = s_dv.size() - 1;
        mk_pl(200);
        repeat (7) push(0, 1, 0, 8'h55);
        push(0, 1, 0, 8'hD5);
        for (int i = 0; i < 200; i++) begin
            push((i == 30 || i == 31), 1'b1, 1'b0, pl[i]);
            if (i == 100) m5 = s_dv.size() - 1;
        end
        idle(3);
        mk_pl(64); send(7, -1); idle(3); m6 = s_dv.size() - 1;
        mk_pl(64); send(7, -1); idle(1);
        mk_pl(64); send(7, -1); idle(3); m7 = s_dv.size() - 1;
        mk_pl(1518); send(7, -1); idle(2);
        mk_pl(1519); send(7, -1); idle(3); m8 = s_dv.size() - 1;
        for (int f = 0; f < 8; f++) begin
            int n;
            int ea;
            n = $urandom_range(56, 200);
            mk_pl(n);
            if ($urandom_range(0, 3) == 0) begin
                int j;
                j = $urandom_range(0, n - 1);
                pl[j] = pl[j] ^ 8'h04;
            end
            ea = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
            send($urandom_range(1, 7), ea);
            idle($urandom_range(1, 4));
        end
        idle(6);

        build_model();

        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) c = crc_step(c, 8'(8'h31 + i));
        chk("pin_crc_check_value", 0, ~c, 32'hCBF4_3926);
        chk("pin_first_beat_latency", sfd1, {30'd0, e_val[sfd1+1], e_val[sfd1+2]}, 32'd1);
        chk("pin_beats_64", m1, beats(sfd1, m1 + 1), 64);
        chk("pin_ok_after_64", m1, e_ok[m1], 1);
        chk("pin_bad_after_64", m1, e_bc[m1], 0);
        chk("pin_beats_runt", m2, beats(sfd2, m2 + 1), 63);
        chk("pin_bad_after_runt", m2, e_bc[m2], 1);
`ifdef RGMII_RX_FCS_CHECK_EN
        chk("pin_ok_after_fcs_err", m3, e_ok[m3], 1);
        chk("pin_bad_after_fcs_err", m3, e_bc[m3], 2);
        chk("pin_ok_after_faults", m4, e_ok[m4], 1);
        chk("pin_bad_after_faults", m4, e_bc[m4], 8);
`else
        chk("pin_ok_after_fcs_err", m3, e_ok[m3], 2);
        chk("pin_bad_after_fcs_err", m3, e_bc[m3], 1);
        chk("pin_ok_after_faults", m4, e_ok[m4], 2);
        chk("pin_bad_after_faults", m4, e_bc[m4], 7);
`endif
        chk("pin_reset_ok", m5, e_ok[m5], 0);
        chk("pin_reset_bad", m5, e_bc[m5], 0);
        chk("pin_reset_quiet", m5, beats(m5 - 70, m5 + 1), 0);
        chk("pin_ok_after_reset_frame", m6, e_ok[m6], 1);
        chk("pin_ok_after_b2b", m7, e_ok[m7], 3);
        chk("pin_ok_after_long", m8, e_ok[m8], 4);
        chk("pin_bad_after_long", m8, e_bc[m8], 1);

        rst        = s_rst[0];
        rx_dv_in   = s_dv[0];
        rx_er_in   = s_er[0];
        rx_data_in = s_dat[0];
        active = 1'b1;
        for (int i = 0; i < nc; i++) begin
            cur = i;
            @(posedge clk125MHz);
            @(negedge clk125MHz);
            #1;
            if (i + 1 < nc) begin
                rst        = s_rst[i+1];
                rx_dv_in   = s_dv[i+1];
                rx_er_in   = s_er[i+1];
                rx_data_in = s_dat[i+1];
            end
        end
        active = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
